id_ex_stage: RTL

ID_EX_STAGE -- requirements
Module: id_ex_stage

---
 rtl/id_ex_stage.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX-stage operand forwarding and load-use detection.
// Stage registers hold the decoded instruction; ALU operands are forwarded
// combinationally from the registered source ids so late writers are seen
// in the same cycle.
module id_ex_stage (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        stall,
    input  logic        flush,
    input  logic        id_valid,
    input  logic [3:0]  id_alu_control,
    input  logic        id_alu_src,
    input  logic [3:0]  id_ctrl,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic [4:0]  id_dest,
    input  logic [31:0] id_rs_data,
    input  logic [31:0] id_rt_data,
    input  logic [31:0] id_imm,
    input  logic        mem_fwd_en,
    input  logic [4:0]  mem_fwd_rd,
    input  logic [31:0] mem_fwd_data,
    input  logic        wb_fwd_en,
    input  logic [4:0]  wb_fwd_rd,
    input  logic [31:0] wb_fwd_data,
    output logic        ex_valid,
    output logic [3:0]  alu_control,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [31:0] ex_store_data,
    output logic [4:0]  ex_dest,
    output logic [3:0]  ex_ctrl,
    output logic        load_use_hazard
);

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned REG_W   = 5;
    localparam int unsigned ALU_W   = 4;
    localparam int unsigned CTRL_W  = 4;
    localparam int unsigned MEM_RD  = 2;

    logic              valid_q,       valid_d;
    logic [ALU_W-1:0]  alu_control_q, alu_control_d;
    logic              alu_src_q,     alu_src_d;
    logic [CTRL_W-1:0] ctrl_q,        ctrl_d;
    logic [REG_W-1:0]  rs_q,          rs_d;
    logic [REG_W-1:0]  rt_q,          rt_d;
    logic [REG_W-1:0]  dest_q,        dest_d;
    logic [DATA_W-1:0] rs_data_q,     rs_data_d;
    logic [DATA_W-1:0] rt_data_q,     rt_data_d;
    logic [DATA_W-1:0] imm_q,         imm_d;

    logic [DATA_W-1:0] rs_fwd;
    logic [DATA_W-1:0] rt_fwd;

    // Select newest producer of a register: EX/MEM beats MEM/WB, r0 never forwarded.
    function automatic logic [DATA_W-1:0] fwd_sel(
        input logic [REG_W-1:0]  id,
        input logic [DATA_W-1:0] reg_data,
        input logic              m_en,
        input logic [REG_W-1:0]  m_rd,
        input logic [DATA_W-1:0] m_data,
        input logic              w_en,
        input logic [REG_W-1:0]  w_rd,
        input logic [DATA_W-1:0] w_data
    );
        logic [DATA_W-1:0] r;
        r = reg_data;
        if (id != REG_W'(0)) begin
            if (m_en && (m_rd == id)) begin
                r = m_data;
            end else if (w_en && (w_rd == id)) begin
                r = w_data;
            end
        end
        return r;
    endfunction

    // Load in EX whose destination is read by the instruction in ID.
    assign load_use_hazard = valid_q & ctrl_q[MEM_RD] & (dest_q != REG_W'(0)) & id_valid
                           & ((dest_q == id_rs) | (dest_q == id_rt));

    // Next-state selection: flush > stall > load-use bubble > capture.
    always_comb begin
        valid_d       = valid_q;
        alu_control_d = alu_control_q;
        alu_src_d     = alu_src_q;
        ctrl_d        = ctrl_q;
        rs_d          = rs_q;
        rt_d          = rt_q;
        dest_d        = dest_q;
        rs_data_d     = rs_data_q;
        rt_data_d     = rt_data_q;
        imm_d         = imm_q;
        if (flush || (!stall && (load_use_hazard || !id_valid))) begin
            valid_d       = 1'b0;
            alu_control_d = '0;
            alu_src_d     = 1'b0;
            ctrl_d        = '0;
            rs_d          = '0;
            rt_d          = '0;
            dest_d        = '0;
            rs_data_d     = '0;
            rt_data_d     = '0;
            imm_d         = '0;
        end else if (!stall) begin
            valid_d       = 1'b1;
            alu_control_d = id_alu_control;
            alu_src_d     = id_alu_src;
            ctrl_d        = id_ctrl;
            rs_d          = id_rs;
            rt_d          = id_rt;
            dest_d        = id_dest;
            rs_data_d     = id_rs_data;
            rt_data_d     = id_rt_data;
            imm_d         = id_imm;
        end
    end

    // Stage registers; reset loads a bubble.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            valid_q       <= 1'b0;
            alu_control_q <= '0;
            alu_src_q     <= 1'b0;
            ctrl_q        <= '0;
            rs_q          <= '0;
            rt_q          <= '0;
            dest_q        <= '0;
            rs_data_q     <= '0;
            rt_data_q     <= '0;
            imm_q         <= '0;
        end else begin
            valid_q       <= valid_d;
            alu_control_q <= alu_control_d;
            alu_src_q     <= alu_src_d;
            ctrl_q        <= ctrl_d;
            rs_q          <= rs_d;
            rt_q          <= rt_d;
            dest_q        <= dest_d;
            rs_data_q     <= rs_data_d;
            rt_data_q     <= rt_data_d;
            imm_q         <= imm_d;
        end
    end

    // Operand forwarding on the registered source ids.
    always_comb begin
        rs_fwd = fwd_sel(rs_q, rs_data_q, mem_fwd_en, mem_fwd_rd, mem_fwd_data,
                         wb_fwd_en, wb_fwd_rd, wb_fwd_data);
        rt_fwd = fwd_sel(rt_q, rt_data_q, mem_fwd_en, mem_fwd_rd, mem_fwd_data,
                         wb_fwd_en, wb_fwd_rd, wb_fwd_data);
    end

    assign ex_valid      = valid_q;
    assign alu_control   = alu_control_q;
    assign alu_a         = rs_fwd;
    assign alu_b         = alu_src_q ? imm_q : rt_fwd;
    assign ex_store_data = rt_fwd;
    assign ex_dest       = dest_q;
    assign ex_ctrl       = ctrl_q;

endmodule
